// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: two halfword beats per 32-bit fetch.
// Optional one-entry line buffer enabled by defining MC_LINE_BUF_EN.
module imem_fetch_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_mc_en,
    input  logic [ADDR_W-1:0] if_mc_addr,
    input  logic              if_mc_flush,
    output logic [31:0]       mc_if_data,
    output logic              mc_if_valid,
    output logic              mc_if_busy,
    output logic [ADDR_W:0]   mc_ram_addr,
    output logic              mc_ram_oe,
    input  logic [15:0]       ram_mc_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       lo_q;
    logic              last;
    logic              accept;
    logic              hit;
    logic              lo_cap;
    logic              hi_cap;
    logic              count_en;
    logic              ram_oe_n;
    logic [ADDR_W:0]   ram_addr_n;

`ifdef MC_LINE_BUF_EN
    logic [ADDR_W-1:0] lb_tag;
    logic [31:0]       lb_data;
    logic              lb_v;

    assign hit = lb_v && (lb_tag == if_mc_addr);
`else
    assign hit = 1'b0;
`endif

    assign last        = (cnt == LAST);
    assign mc_if_busy  = (state == LO) || (state == HI);
    assign mc_if_valid = (state == DONE);

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        lo_cap     = 1'b0;
        hi_cap     = 1'b0;
        count_en   = 1'b0;
        ram_oe_n   = 1'b0;
        ram_addr_n = mc_ram_addr;
        unique case (state)
            IDLE, DONE: begin
                if (if_mc_en) begin
                    accept  = 1'b1;
                    state_n = hit ? DONE : LO;
                end else begin
                    state_n = IDLE;
                end
            end
            LO: begin
                if (if_mc_flush) begin
                    state_n = IDLE;
                end else if (last) begin
                    lo_cap  = 1'b1;
                    state_n = HI;
                end else begin
                    count_en = 1'b1;
                end
            end
            HI: begin
                if (if_mc_flush) begin
                    state_n = IDLE;
                end else if (last) begin
                    hi_cap  = 1'b1;
                    state_n = DONE;
                end else begin
                    count_en = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Address is registered, so it is computed for the state being entered.
        if (state_n == LO) begin
            ram_oe_n   = 1'b1;
            ram_addr_n = accept ? {if_mc_addr, 1'b0} : {addr_q, 1'b0};
        end else if (state_n == HI) begin
            ram_oe_n   = 1'b1;
            ram_addr_n = {addr_q, 1'b1};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            lo_q        <= 16'd0;
            mc_if_data  <= 32'd0;
            mc_ram_addr <= '0;
            mc_ram_oe   <= 1'b0;
        end else begin
            state       <= state_n;
            mc_ram_oe   <= ram_oe_n;
            mc_ram_addr <= ram_addr_n;
            cnt         <= count_en ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                addr_q <= if_mc_addr;
            end
            if (lo_cap) begin
                lo_q <= ram_mc_data;
            end
            if (hi_cap) begin
                mc_if_data <= {ram_mc_data, lo_q};
            end
`ifdef MC_LINE_BUF_EN
            if (accept && hit) begin
                mc_if_data <= lb_data;
            end
`endif
        end
    end

`ifdef MC_LINE_BUF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            lb_v    <= 1'b0;
            lb_tag  <= '0;
            lb_data <= 32'd0;
        end else if (hi_cap) begin
            lb_v    <= 1'b1;
            lb_tag  <= addr_q;
            lb_data <= {ram_mc_data, lo_q};
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed steps, then random traffic
// checked against a cycle-age transaction model of the fetch.
module tb_imem_fetch_responder;

    localparam int W  = 2;
    localparam int AW = 18;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_mc_en;
    logic [AW-1:0] if_mc_addr;
    logic          if_mc_flush;
    logic [31:0]   mc_if_data;
    logic          mc_if_valid;
    logic          mc_if_busy;
    logic [AW:0]   mc_ram_addr;
    logic          mc_ram_oe;
    logic [15:0]   ram_mc_data;

    int checks = 0;
    int errors = 0;

    imem_fetch_responder #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .if_mc_en    (if_mc_en),
        .if_mc_addr  (if_mc_addr),
        .if_mc_flush (if_mc_flush),
        .mc_if_data  (mc_if_data),
        .mc_if_valid (mc_if_valid),
        .mc_if_busy  (mc_if_busy),
        .mc_ram_addr (mc_ram_addr),
        .mc_ram_oe   (mc_ram_oe),
        .ram_mc_data (ram_mc_data)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] ram_fn(input logic [AW:0] h);
        logic [31:0] t;
        if (h == 19'h20) return 16'h5678;
        if (h == 19'h21) return 16'h1234;
        t = 32'(h) * 32'd40503 + 32'hA5C3;
        return t[15:0] ^ {h[18:16], 13'd0};
    endfunction

    assign ram_mc_data = ram_fn(mc_ram_addr);

    // Model: age counts edges since a request was accepted.
    bit          m_act;
    int          m_age;
    logic [AW-1:0] m_a;
    logic [31:0] m_data;
    logic [AW:0] m_ra;
    bit          lb_v;
    logic [AW-1:0] lb_tag;
    logic [31:0] lb_data;

    task automatic model_edge();
        bit use_buf;
`ifdef MC_LINE_BUF_EN
        use_buf = 1'b1;
`else
        use_buf = 1'b0;
`endif
        if (reset) begin
            m_act  = 0;
            m_age  = 0;
            m_data = 0;
            m_ra   = 0;
            lb_v   = 0;
        end else if (m_act && m_age < 2 * W) begin
            if (if_mc_flush) begin
                m_act = 0;
            end else begin
                m_age++;
                if (m_age == 2 * W) begin
                    m_data  = {ram_fn({m_a, 1'b1}), ram_fn({m_a, 1'b0})};
                    lb_v    = 1;
                    lb_tag  = m_a;
                    lb_data = m_data;
                end
            end
        end else if (if_mc_en) begin
            m_act = 1;
            if (use_buf && lb_v && lb_tag == if_mc_addr) begin
                m_age  = 2 * W;
                m_data = lb_data;
            end else begin
                m_age = 0;
                m_a   = if_mc_addr;
            end
        end else begin
            m_act = 0;
        end
        if (m_act && m_age < 2 * W) m_ra = {m_a, m_age >= W};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit busy;
        busy = m_act && (m_age < 2 * W);
        chk("busy", 32'(mc_if_busy), 32'(busy));
        chk("oe", 32'(mc_ram_oe), 32'(busy));
        chk("valid", 32'(mc_if_valid), 32'(m_act && m_age == 2 * W));
        chk("data", mc_if_data, m_data);
        chk("ram_addr", 32'(mc_ram_addr), 32'(m_ra));
    endtask

    // One clock: model sees inputs at the edge, outputs sampled at negedge.
    task automatic step();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_model();
    endtask

    task automatic do_reset();
        reset       = 1;
        if_mc_en    = 0;
        if_mc_flush = 0;
        step();
        reset = 0;
    endtask

    initial begin
        reset       = 1;
        if_mc_en    = 0;
        if_mc_addr  = '0;
        if_mc_flush = 0;
        @(negedge clock);

        // Reset state
        do_reset();
        chk("rst_data", mc_if_data, 32'h0);
        chk("rst_addr", 32'(mc_ram_addr), 32'h0);

        // Single fetch of word 0x10
        if_mc_en   = 1;
        if_mc_addr = 18'h10;
        step();
        if_mc_en = 0;
        chk("beat0_addr", 32'(mc_ram_addr), 32'h20);
        step();
        chk("beat0_addr2", 32'(mc_ram_addr), 32'h20);
        step();
        chk("beat1_addr", 32'(mc_ram_addr), 32'h21);
        step();
        chk("beat1_addr2", 32'(mc_ram_addr), 32'h21);
        step();
        chk("lat_valid", 32'(mc_if_valid), 32'h1);
        chk("lat_data", mc_if_data, 32'h12345678);
        step();
        chk("idle_valid", 32'(mc_if_valid), 32'h0);

        // Back-to-back 0x10 then 0x11 with en held
        do_reset();
        if_mc_en   = 1;
        if_mc_addr = 18'h10;
        step();
        if_mc_addr = 18'h11;
        repeat (4) step();
        chk("b2b_v0", 32'(mc_if_valid), 32'h1);
        chk("b2b_d0", mc_if_data, 32'h12345678);
        step();
        chk("b2b_busy", 32'(mc_if_busy), 32'h1);
        repeat (4) step();
        chk("b2b_v1", 32'(mc_if_valid), 32'h1);
        chk("b2b_d1", mc_if_data, {ram_fn(19'h23), ram_fn(19'h22)});
        if_mc_en = 0;
        step();

        // Flush during HI
        do_reset();
        if_mc_en   = 1;
        if_mc_addr = 18'h10;
        step();
        if_mc_en = 0;
        repeat (2) step();
        if_mc_flush = 1;
        if_mc_en    = 1;
        step();
        if_mc_flush = 0;
        if_mc_en    = 0;
        chk("flush_busy", 32'(mc_if_busy), 32'h0);
        chk("flush_data", mc_if_data, 32'h0);
        repeat (6) begin
            step();
            chk("flush_novalid", 32'(mc_if_valid), 32'h0);
        end

        // Reset during LO, then a clean fetch
        if_mc_en   = 1;
        if_mc_addr = 18'h10;
        step();
        if_mc_en = 0;
        do_reset();
        chk("rlo_oe", 32'(mc_ram_oe), 32'h0);
        chk("rlo_busy", 32'(mc_if_busy), 32'h0);
        chk("rlo_addr", 32'(mc_ram_addr), 32'h0);

        // Address changes while busy are ignored
        if_mc_en   = 1;
        if_mc_addr = 18'h10;
        step();
        if_mc_en   = 0;
        if_mc_addr = 18'h3F;
        repeat (4) step();
        chk("hold_data", mc_if_data, 32'h12345678);
        step();

`ifdef MC_LINE_BUF_EN
        // Repeat of the buffered word hits with no RAM access
        if_mc_en   = 1;
        if_mc_addr = 18'h10;
        step();
        if_mc_en = 0;
        chk("hit_valid", 32'(mc_if_valid), 32'h1);
        chk("hit_oe", 32'(mc_ram_oe), 32'h0);
        chk("hit_data", mc_if_data, 32'h12345678);
        if_mc_en   = 1;
        if_mc_addr = 18'h11;
        step();
        if_mc_en = 0;
        chk("miss_busy", 32'(mc_if_busy), 32'h1);
        repeat (4) step();
`endif

        // Top-of-memory word: no wrap inside the word
        if_mc_en   = 1;
        if_mc_addr = '1;
        step();
        if_mc_en = 0;
        chk("wrap_lo", 32'(mc_ram_addr), 32'h7FFFE);
        repeat (2) step();
        chk("wrap_hi", 32'(mc_ram_addr), 32'h7FFFF);
        repeat (3) step();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 79) == 0);
            if_mc_en    = ($urandom_range(0, 3) != 0);
            if_mc_flush = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: if_mc_addr = 18'h10;
                1: if_mc_addr = 18'h11;
                2: if_mc_addr = '1;
                default: if_mc_addr = AW'($urandom);
            endcase
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
